wr_ptr_full_ctrl: RTL

Write-domain pointer and full-flag controller for the async FIFO. It runs on `wr_clk` and accepts pushes, producing the binary RAM write address and the Gray-coded write pointer. That Gray pointer is the value handed to the write-pointer 2-FF synchronizer for transfer into the read domain. It consumes the read pointer already synchronized into the write domain and derives `wr_full`, `wr_almost_full`, the occupancy level and a sticky overflow flag.

---
 rtl/wr_ptr_full_ctrl.sv | 70 +++++++
 1 files changed

// File: rtl/wr_ptr_full_ctrl.sv
// Write-domain pointer and full-flag controller for the async FIFO.
// Produces the RAM write address, the Gray write pointer and the write-side flags.
module wr_ptr_full_ctrl #(
    parameter int unsigned ADD_WIDTH = 3,
    parameter int unsigned AF_THRESH = 6
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst,
    input  logic                 wr_en,
    input  logic [ADD_WIDTH:0]   wr_rptr_sync,
    input  logic                 wr_ovf_clr,
    output logic                 wr_ram_en,
    output logic [ADD_WIDTH-1:0] wr_addr,
    output logic [ADD_WIDTH:0]   wr_ptr_gray,
    output logic                 wr_full,
    output logic                 wr_almost_full,
    output logic [ADD_WIDTH:0]   wr_level,
    output logic                 wr_overflow
);

    localparam int unsigned PW = ADD_WIDTH + 1;

    logic          acc;
    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] gray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] full_cmp;
    logic [PW-1:0] level_next;

    // Next-pointer, read-pointer decode and occupancy; flags all derive from *_next.
    always_comb begin
        rbin       = '0;
        acc        = wr_en & ~wr_full;
        wbin_next  = wbin + PW'(acc);
        gray_next  = (wbin_next >> 1) ^ wbin_next;
        for (int i = 0; i < int'(PW); i++) begin
            rbin[i] = ^(wr_rptr_sync >> i);
        end
        full_cmp   = {~wr_rptr_sync[ADD_WIDTH:ADD_WIDTH-1], wr_rptr_sync[ADD_WIDTH-2:0]};
        level_next = wbin_next - rbin;
    end

    assign wr_ram_en = acc;
    assign wr_addr   = wbin[ADD_WIDTH-1:0];

    // Pointer and flag registers; overflow set dominates clear.
    always_ff @(posedge wr_clk) begin
        if (!wr_rst) begin
            wbin           <= '0;
            wr_ptr_gray    <= '0;
            wr_full        <= 1'b0;
            wr_almost_full <= 1'b0;
            wr_level       <= '0;
            wr_overflow    <= 1'b0;
        end else begin
            wbin           <= wbin_next;
            wr_ptr_gray    <= gray_next;
            wr_full        <= (gray_next == full_cmp);
            wr_almost_full <= (level_next >= PW'(AF_THRESH));
            wr_level       <= level_next;
            if (wr_en & wr_full) begin
                wr_overflow <= 1'b1;
            end else if (wr_ovf_clr) begin
                wr_overflow <= 1'b0;
            end
        end
    end

endmodule
